// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D sampling scheduler: channel map, FSM states,
// slot type and SPI command builder.
package a2d_pkg;

  localparam logic [2:0] CH_BATT   = 3'd0;
  localparam logic [2:0] CH_CURR   = 3'd1;
  localparam logic [2:0] CH_BRAKE  = 3'd3;
  localparam logic [2:0] CH_TORQUE = 3'd4;

  typedef enum logic [1:0] {IDLE, CMD, GAP, READ} sched_state_t;

  typedef logic [1:0] slot_t;

  function automatic logic [15:0] mk_cmd(input logic [2:0] chan);
    return {2'b00, chan, 11'h000};
  endfunction

  // Slot order batt -> curr -> brake -> torque
  function automatic logic [2:0] slot_chan(input slot_t slot);
    case (slot)
      2'd0:    return CH_BATT;
      2'd1:    return CH_CURR;
      2'd2:    return CH_BRAKE;
      default: return CH_TORQUE;
    endcase
  endfunction

endpackage

// File: rtl/a2d_slot_regs.sv
// Four 12-bit conversion result registers with a one-cycle per-slot update
// strobe, written by slot index plus load enable.
module a2d_slot_regs
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [1:0]  slot,
  input  logic [11:0] din,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic [3:0]  smpl_vld
);

  logic [11:0] res_q [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [11:0] res_reg;
    logic        vld_reg;
    logic        hit;

    assign hit = ld && (slot == slot_t'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_reg <= 12'h000;
        vld_reg <= 1'b0;
      end else begin
        vld_reg <= hit;
        if (hit) res_reg <= din;
      end
    end

    assign res_q[gi]    = res_reg;
    assign smpl_vld[gi] = vld_reg;
  end

  assign batt   = res_q[0];
  assign curr   = res_q[1];
  assign brake  = res_q[2];
  assign torque = res_q[3];

endmodule

// File: rtl/a2d_sample_sched.sv
// Round-robin owner of the shared A2D SPI master: each conversion is a command
// transaction, one dead cycle, then a read-back transaction carrying the result.
module a2d_sample_sched
  import a2d_pkg::*;
#(
  parameter int FAST_SIM = 1,
  parameter int TIMEOUT  = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic [3:0]  smpl_vld,
  output logic        spi_err
);

  localparam int IW = (FAST_SIM != 0) ? 8 : 14;
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t  state_reg;
  slot_t         slot_reg;
  logic [IW-1:0] ivl_reg;
  logic [TW-1:0] tmo_reg;
  logic          wrt_reg;
  logic [15:0]   cmd_reg;
  logic          err_reg;

  logic        cnv_req;
  logic        tmo_hit;
  logic        ld;
  logic [15:0] slot_cmd;
  logic        unused_rd_hi;

  assign cnv_req      = &ivl_reg;
  assign tmo_hit      = (tmo_reg == TW'(TIMEOUT));
  assign ld           = (state_reg == READ) && spi_done;
  assign slot_cmd     = mk_cmd(slot_chan(slot_reg));
  assign unused_rd_hi = ^spi_rd[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ivl_reg <= '0;
    else        ivl_reg <= ivl_reg + 1'b1;
  end

  // spi_done is tested before the timeout so a coincident done counts as completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      slot_reg  <= '0;
      tmo_reg   <= '0;
      wrt_reg   <= 1'b0;
      cmd_reg   <= 16'h0000;
      err_reg   <= 1'b0;
    end else begin
      wrt_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cnv_req) begin
            wrt_reg   <= 1'b1;
            cmd_reg   <= slot_cmd;
            tmo_reg   <= '0;
            state_reg <= CMD;
          end
        end
        CMD: begin
          if (spi_done) begin
            state_reg <= GAP;
          end else if (tmo_hit) begin
            err_reg   <= 1'b1;
            slot_reg  <= slot_reg + 1'b1;
            state_reg <= IDLE;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        GAP: begin
          wrt_reg   <= 1'b1;
          tmo_reg   <= '0;
          state_reg <= READ;
        end
        READ: begin
          if (spi_done) begin
            slot_reg  <= slot_reg + 1'b1;
            state_reg <= IDLE;
          end else if (tmo_hit) begin
            err_reg   <= 1'b1;
            slot_reg  <= slot_reg + 1'b1;
            state_reg <= IDLE;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  a2d_slot_regs u_slot_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld       (ld),
    .slot     (slot_reg),
    .din      (spi_rd[11:0]),
    .batt     (batt),
    .curr     (curr),
    .brake    (brake),
    .torque   (torque),
    .smpl_vld (smpl_vld)
  );

  assign spi_wrt = wrt_reg;
  assign spi_cmd = cmd_reg;
  assign spi_err = err_reg;

endmodule

// File: doc/a2d_sample_sched.md
Name: a2d_sample_sched

Overview:
- Round-robin scheduler that owns the shared SPI master to the external 8-channel A2D.
- Periodically converts battery, current, brake and torque channels and holds the latest 12-bit result of each.
- Feeds batt/curr/torque into the sensor-conditioning datapath and brake into drive control.
- One SPI master, four requesters; this block is the only initiator on the bus.

Parameters:
- FAST_SIM, 1, when 1 the inter-conversion interval counter is 8 bits (256 clk); when 0 it is 14 bits (16384 clk).
- TIMEOUT, 4095, max clk cycles to wait for spi_done before aborting a transaction.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- spi_wrt  output  1  one-cycle pulse starting an SPI transaction
- spi_cmd  output  16  command word, valid on and held after spi_wrt
- spi_done  input  1  one-cycle pulse, SPI transaction complete
- spi_rd  input  16  data shifted in; [11:0] is the conversion result
- batt  output  12  latest battery reading (channel 0)
- curr  output  12  latest current reading (channel 1)
- brake  output  12  latest brake reading (channel 3)
- torque  output  12  latest torque reading (channel 4)
- smpl_vld  output  4  one-cycle strobe per slot {torque,brake,curr,batt} when that register updates
- spi_err  output  1  sticky flag; set on timeout, cleared only by reset

Behaviour:
- Reset values:
  - all result outputs 12'h000; smpl_vld 0; spi_wrt 0; spi_cmd 16'h0000; spi_err 0.
  - State IDLE, slot pointer 0, interval counter 0, timeout counter 0.
- Slot order: batt(ch0) -> curr(ch1) -> brake(ch3) -> torque(ch4) -> batt. Slot pointer is 2 bits and wraps 3 -> 0.
- Command format: {2'b00, chan[2:0], 11'h000}. spi_cmd changes only in the cycle spi_wrt is asserted.
- Interval counter:
  - free-runs from reset and wraps;
  - the all-ones value is the conversion request (cnv_req);
  - a cnv_req arriving while not in IDLE is dropped, never queued.
- FSM states:
  - IDLE: on cnv_req, pulse spi_wrt with the channel command for the current slot -> CMD.
  - CMD: wait for spi_done -> GAP.
  - GAP: exactly one dead cycle, then pulse spi_wrt with the same command (this read-back transaction returns the result) -> READ.
  - READ: on spi_done, in the next clk, load spi_rd[11:0] into the slot's register, pulse smpl_vld[slot] for 1 cycle, advance the slot -> IDLE.
- Latency: the result is visible 1 clk after the second spi_done. The minimum full cycle is 2 SPI transactions + 2 clk.
- Timeout:
  - The timeout counter clears on each spi_wrt and increments in CMD/READ.
  - When it reaches TIMEOUT without spi_done: set spi_err, leave the result register unchanged, no smpl_vld, advance the slot -> IDLE.
- Unexpected events:
  - spi_done in IDLE or GAP is ignored.
  - spi_done coinciding with timeout expiry counts as completion and does not set spi_err.
- Reset mid-transaction returns everything to reset values immediately (async). The first post-reset conversion is batt.
- Registered outputs only; no combinational path from spi_rd to the result outputs.

Decomposition:
- Shared package a2d_pkg:
  - channel constants CH_BATT=3'd0, CH_CURR=3'd1, CH_BRAKE=3'd3, CH_TORQUE=3'd4;
  - enum typedef sched_state_t {IDLE,CMD,GAP,READ};
  - 2-bit slot_t;
  - function mk_cmd(chan) returning the 16-bit command.
- Sub-module a2d_slot_regs: the four 12-bit result registers plus smpl_vld decode, written by slot index + load strobe.
- FSM, interval counter and timeout counter stay in the top level.

Test Plan:
1. Reset release, FAST_SIM=1, SPI model returning 16'h0A98 for ch0 -> at clk 255 spi_wrt with spi_cmd 16'h0000; after second done, batt=12'hA98 with smpl_vld=4'b0001 for one cycle; other outputs 0.
2. Four consecutive cnv_req periods, model returns channel-dependent data (0x111,0x222,0x333,0x444) -> batt=111, curr=222, brake=333, torque=444; spi_cmd sequence 0000,0800,1800,2000; fifth conversion is batt again.
3. SPI model delays done beyond the next cnv_req -> extra request dropped; exactly two spi_wrt per conversion; slot order unbroken.
4. SPI model never returns done on curr read -> spi_err rises after TIMEOUT cycles, curr unchanged, next conversion targets brake (cmd 16'h1800); spi_err stays 1.
5. Assert rst_n low while in GAP -> outputs 0, spi_err 0, next conversion after release is batt.
6. Spurious spi_done pulse in IDLE -> no register update, no smpl_vld, no state change.
